// File: rtl/ps2_kbd_cmd_sched.sv
// PS2 keyboard TX command scheduler: arbitrates two requesters and sequences cmd[+arg] bytes
// into the port with per-byte ACK wait, NACK retry and ck1us-based timeout.
module ps2_kbd_cmd_sched #(
    parameter int unsigned TIMEOUT_US = 20000,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic       clk6x,
    input  logic       reset,
    input  logic       ck1us,

    input  logic       req0_valid,
    input  logic [7:0] req0_cmd,
    input  logic [7:0] req0_arg,
    input  logic       req0_has_arg,
    output logic       req0_ready,
    output logic       req0_done,
    output logic [7:0] req0_status,

    input  logic       req1_valid,
    input  logic [7:0] req1_cmd,
    input  logic [7:0] req1_arg,
    input  logic       req1_has_arg,
    output logic       req1_ready,
    output logic       req1_done,
    output logic [7:0] req1_status,

    output logic [7:0] cmd_tx_o,
    output logic       cmd_tx_v_o,
    input  logic       cmd_tx_deq_i,
    input  logic       tx_acked_i,
    input  logic       tx_errd_i,

    output logic       sched_busy_o,
    output logic       cur_owner_o
);

    localparam int unsigned TW = (TIMEOUT_US > 0) ? $clog2(TIMEOUT_US + 1) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_US);
    localparam logic [RW-1:0] RETRY_VAL   = RW'(MAX_RETRY);

    localparam logic [7:0] STATUS_ACK  = 8'hFA;
    localparam logic [7:0] STATUS_NACK = 8'hFE;
    localparam logic [7:0] STATUS_TMO  = 8'hFD;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StOffer,
        StWait,
        StDone
    } state_e;

    state_e          state;
    logic            rr;
    logic            pick;
    logic [7:0]      cmd_q;
    logic [7:0]      arg_q;
    logic            has_arg_q;
    logic            byte_arg;
    logic [RW-1:0]   retries;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nxt;
    logic            timeout_hit;
    logic            fin;
    logic [7:0]      fin_code;

    // Tie goes to the requester that was not granted last.
    always_comb begin
        pick = (req0_valid && req1_valid) ? ~rr : req1_valid;
    end

    always_comb begin
        timer_nxt = timer;
        if (ck1us && (timer != TIMEOUT_VAL)) begin
            timer_nxt = timer + TW'(1);
        end
        timeout_hit = (timer_nxt >= TIMEOUT_VAL);
    end

    // Command completion: device response beats a timeout landing in the same cycle.
    always_comb begin
        fin      = 1'b0;
        fin_code = STATUS_ACK;
        case (state)
            StOffer: begin
                if (!cmd_tx_deq_i && timeout_hit) begin
                    fin      = 1'b1;
                    fin_code = STATUS_TMO;
                end
            end
            StWait: begin
                if (tx_errd_i) begin
                    if (retries >= RETRY_VAL) begin
                        fin      = 1'b1;
                        fin_code = STATUS_NACK;
                    end
                end else if (tx_acked_i) begin
                    if (byte_arg || !has_arg_q) begin
                        fin      = 1'b1;
                        fin_code = STATUS_ACK;
                    end
                end else if (timeout_hit) begin
                    fin      = 1'b1;
                    fin_code = STATUS_TMO;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk6x or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            rr           <= 1'b1;
            cmd_q        <= 8'h00;
            arg_q        <= 8'h00;
            has_arg_q    <= 1'b0;
            byte_arg     <= 1'b0;
            retries      <= '0;
            timer        <= '0;
            cmd_tx_o     <= 8'h00;
            cmd_tx_v_o   <= 1'b0;
            sched_busy_o <= 1'b0;
            cur_owner_o  <= 1'b0;
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            req0_done    <= 1'b0;
            req1_done    <= 1'b0;
            req0_status  <= 8'h00;
            req1_status  <= 8'h00;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;

            case (state)
                StIdle: begin
                    if (req0_valid || req1_valid) begin
                        // Latch here so ready truly means the request is captured.
                        state        <= StGrant;
                        sched_busy_o <= 1'b1;
                        cur_owner_o  <= pick;
                        cmd_q        <= pick ? req1_cmd : req0_cmd;
                        arg_q        <= pick ? req1_arg : req0_arg;
                        has_arg_q    <= pick ? req1_has_arg : req0_has_arg;
                        req0_ready   <= ~pick;
                        req1_ready   <= pick;
                    end
                end
                StGrant: begin
                    rr         <= cur_owner_o;
                    byte_arg   <= 1'b0;
                    retries    <= '0;
                    timer      <= '0;
                    cmd_tx_o   <= cmd_q;
                    cmd_tx_v_o <= 1'b1;
                    state      <= StOffer;
                end
                StOffer: begin
                    timer <= timer_nxt;
                    if (cmd_tx_deq_i) begin
                        cmd_tx_v_o <= 1'b0;
                        state      <= StWait;
                    end
                end
                StWait: begin
                    if (tx_errd_i) begin
                        if (retries < RETRY_VAL) begin
                            // cmd_tx_o still holds the byte being retried.
                            retries    <= retries + RW'(1);
                            timer      <= '0;
                            cmd_tx_v_o <= 1'b1;
                            state      <= StOffer;
                        end
                    end else if (tx_acked_i) begin
                        if (!byte_arg && has_arg_q) begin
                            byte_arg   <= 1'b1;
                            retries    <= '0;
                            timer      <= '0;
                            cmd_tx_o   <= arg_q;
                            cmd_tx_v_o <= 1'b1;
                            state      <= StOffer;
                        end
                    end else begin
                        timer <= timer_nxt;
                    end
                end
                StDone: begin
                    state        <= StIdle;
                    sched_busy_o <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            if (fin) begin
                state      <= StDone;
                cmd_tx_v_o <= 1'b0;
                if (cur_owner_o) begin
                    req1_done   <= 1'b1;
                    req1_status <= fin_code;
                end else begin
                    req0_done   <= 1'b1;
                    req0_status <= fin_code;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_cmd_sched.sv
// Randomized scoreboard bench for ps2_kbd_cmd_sched with a device responder and a done monitor.
module tb_ps2_kbd_cmd_sched;

    localparam int TO = 50;
    localparam int MR = 2;

    logic       clk6x = 1'b0;
    logic       reset;
    logic       ck1us;
    logic       req0_valid, req0_has_arg, req0_ready, req0_done;
    logic [7:0] req0_cmd, req0_arg, req0_status;
    logic       req1_valid, req1_has_arg, req1_ready, req1_done;
    logic [7:0] req1_cmd, req1_arg, req1_status;
    logic [7:0] cmd_tx_o;
    logic       cmd_tx_v_o, cmd_tx_deq_i, tx_acked_i, tx_errd_i;
    logic       sched_busy_o, cur_owner_o;

    ps2_kbd_cmd_sched #(.TIMEOUT_US(TO), .MAX_RETRY(MR)) dut (
        .clk6x(clk6x), .reset(reset), .ck1us(ck1us),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_arg(req0_arg),
        .req0_has_arg(req0_has_arg), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_status(req0_status),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_arg(req1_arg),
        .req1_has_arg(req1_has_arg), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_status(req1_status),
        .cmd_tx_o(cmd_tx_o), .cmd_tx_v_o(cmd_tx_v_o), .cmd_tx_deq_i(cmd_tx_deq_i),
        .tx_acked_i(tx_acked_i), .tx_errd_i(tx_errd_i),
        .sched_busy_o(sched_busy_o), .cur_owner_o(cur_owner_o)
    );

    always #5 clk6x = ~clk6x;

    typedef struct {
        int owner;
        int status;
    } done_t;

    int    checks = 0;
    int    errors = 0;
    int    exp_bytes[$];
    int    plan[$];          // per offered byte: 0 ack, 1 nack, 2 never deq, 3 deq then silence
    done_t exp_done[$];
    int    last_grant = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic int next_kind(input int forced, input int bidx);
        int r;
        if (forced == -1) begin
            r = $urandom_range(0, 15);
            if (r < 10) return 0;
            if (r < 14) return 1;
            if (r == 14) return 2;
            return 3;
        end
        if (forced == 10) return (bidx == 0) ? 0 : 1;
        return forced;
    endfunction

    // Reference: list of byte offers and the single final status of one command.
    function automatic void model_push(input int owner, input int cmd, input int arg,
                                       input bit ha, input int forced);
        int    nbytes;
        int    status;
        int    att;
        int    k;
        bit    byte_ok;
        done_t e;
        nbytes = ha ? 2 : 1;
        status = 'hFA;
        for (int b = 0; b < nbytes; b++) begin
            att     = 0;
            byte_ok = 1'b0;
            while (!byte_ok) begin
                k = next_kind(forced, b);
                exp_bytes.push_back((b == 0) ? cmd : arg);
                plan.push_back(k);
                if (k == 0) begin
                    byte_ok = 1'b1;
                end else if (k == 1) begin
                    att++;
                    if (att > MR) begin
                        status  = 'hFE;
                        byte_ok = 1'b1;
                    end
                end else begin
                    status  = 'hFD;
                    byte_ok = 1'b1;
                end
            end
            if (status != 'hFA) break;
        end
        e.owner  = owner;
        e.status = status;
        exp_done.push_back(e);
    endfunction

    task automatic drive_req(input int r, input bit v, input int c, input int a, input bit h);
        if (r == 0) begin
            req0_valid = v; req0_cmd = 8'(c); req0_arg = 8'(a); req0_has_arg = h;
        end else begin
            req1_valid = v; req1_cmd = 8'(c); req1_arg = 8'(a); req1_has_arg = h;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sched_busy_o || exp_done.size() != 0) && n < 3000) begin
            @(negedge clk6x);
            n++;
        end
        chk("drain_in_time", 32'(n < 3000), 1);
        chk("busy_low_after", sched_busy_o, 0);
    endtask

    // Single request from idle: ready after one cycle, first byte offered the next.
    task automatic issue(input int r, input int c, input int a, input bit h, input int forced);
        int n;
        drive_req(r, 1'b1, c, a, h);
        @(negedge clk6x);
        n = 1;
        while (!(r ? req1_ready : req0_ready) && n < 50) begin
            @(negedge clk6x);
            n++;
        end
        chk("ready_latency", n, 1);
        chk("ready_other", r ? req0_ready : req1_ready, 0);
        model_push(r, c, a, h, forced);
        last_grant = r;
        drive_req(r, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
        @(negedge clk6x);
        chk("ready_one_cycle", r ? req1_ready : req0_ready, 0);
        chk("offer_latency", cmd_tx_v_o, 1);
    endtask

    // Both requesters keep asking; each grant must go to the one not served last.
    task automatic issue_both(input int forced);
        int c[2];
        int a[2];
        bit h[2];
        int cnt[2];
        int n;
        int got;
        int w;
        for (int i = 0; i < 2; i++) begin
            c[i] = $urandom_range(0, 255);
            a[i] = $urandom_range(0, 255);
            h[i] = 1'($urandom);
            cnt[i] = 0;
            drive_req(i, 1'b1, c[i], a[i], h[i]);
        end
        for (int g = 0; g < 4; g++) begin
            w = (req0_valid && req1_valid) ? 1 - last_grant : (req1_valid ? 1 : 0);
            @(negedge clk6x);
            n = 1;
            while (!req0_ready && !req1_ready && n < 3000) begin
                @(negedge clk6x);
                n++;
            end
            chk("tie_ready_in_time", 32'(n < 3000), 1);
            got = req1_ready ? 1 : 0;
            chk("tie_grant", got, w);
            model_push(got, c[got], a[got], h[got], forced);
            last_grant = got;
            cnt[got]++;
            if (cnt[got] < 2) begin
                c[got] = $urandom_range(0, 255);
                a[got] = $urandom_range(0, 255);
                h[got] = 1'($urandom);
                drive_req(got, 1'b1, c[got], a[got], h[got]);
            end else begin
                drive_req(got, 1'b0, 0, 0, 1'b0);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, sched_busy_o, 0);
        chk({tag, "_tx_v"}, cmd_tx_v_o, 0);
        chk({tag, "_tx"}, cmd_tx_o, 0);
        chk({tag, "_owner"}, cur_owner_o, 0);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
        chk({tag, "_done0"}, req0_done, 0);
        chk({tag, "_done1"}, req1_done, 0);
        chk({tag, "_status0"}, req0_status, 0);
        chk({tag, "_status1"}, req1_status, 0);
    endtask

    // Done monitor plus ck1us source; counts strobes since the latest offer began.
    initial begin : monitor
        bit    vo_prev;
        bit    ck_prev;
        int    tick;
        int    own;
        done_t e;
        vo_prev = 1'b0;
        ck_prev = 1'b0;
        tick    = 0;
        ck1us   = 1'b0;
        forever begin
            @(negedge clk6x);
            if (reset) begin
                vo_prev = 1'b0;
                ck_prev = 1'b0;
                ck1us   = 1'b0;
            end else begin
                if (cmd_tx_v_o && !vo_prev) tick = 0;
                else if (ck_prev) tick++;
                vo_prev = cmd_tx_v_o;
                if (req0_done || req1_done) begin
                    chk("done_single", 32'(req0_done && req1_done), 0);
                    if (exp_done.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        e   = exp_done.pop_front();
                        own = req1_done ? 1 : 0;
                        chk("done_owner", own, e.owner);
                        chk("done_status", own ? req1_status : req0_status, e.status);
                        chk("done_cur_owner", cur_owner_o, e.owner);
                        chk("done_busy", sched_busy_o, 1);
                        if (e.status == 'hFD) chk("timeout_ticks", tick, TO);
                    end
                end
                ck_prev = ($urandom_range(0, 3) == 0);
                ck1us   = ck_prev;
            end
        end
    end

    // Device/port model: takes offered bytes and answers according to the plan queue.
    initial begin : responder
        int k;
        int n;
        cmd_tx_deq_i = 1'b0;
        tx_acked_i   = 1'b0;
        tx_errd_i    = 1'b0;
        forever begin
            @(negedge clk6x);
            cmd_tx_deq_i = 1'b0;
            tx_acked_i   = 1'b0;
            tx_errd_i    = 1'b0;
            if (!reset && cmd_tx_v_o) begin
                if (exp_bytes.size() == 0) begin
                    chk("offer_unexpected", 1, 0);
                    k = 0;
                end else begin
                    chk("offer_byte", cmd_tx_o, exp_bytes.pop_front());
                    k = plan.pop_front();
                end
                repeat ($urandom_range(0, 4)) @(negedge clk6x);
                if (k == 2) begin
                    n = 0;
                    while (cmd_tx_v_o && n < 1000) begin
                        @(negedge clk6x);
                        n++;
                    end
                end else begin
                    chk("offer_held", cmd_tx_v_o, 1);
                    cmd_tx_deq_i = 1'b1;
                    @(negedge clk6x);
                    cmd_tx_deq_i = 1'b0;
                    chk("offer_drop_after_deq", cmd_tx_v_o, 0);
                    if (k == 3) begin
                        n = 0;
                        while (sched_busy_o && n < 1000) begin
                            @(negedge clk6x);
                            n++;
                        end
                    end else begin
                        repeat ($urandom_range(0, 6)) @(negedge clk6x);
                        if (k == 0) tx_acked_i = 1'b1;
                        else tx_errd_i = 1'b1;
                    end
                end
            end else if (!reset && !sched_busy_o && $urandom_range(0, 7) == 0) begin
                // Stray port strobes while idle must be ignored.
                case ($urandom_range(0, 2))
                    0: tx_acked_i = 1'b1;
                    1: tx_errd_i = 1'b1;
                    default: cmd_tx_deq_i = 1'b1;
                endcase
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk6x);
        errors++;
        $display("FAIL watchdog: actual cycle budget exceeded required finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        reset = 1'b1;
        drive_req(0, 1'b0, 0, 0, 1'b0);
        drive_req(1, 1'b0, 0, 0, 1'b0);
        repeat (3) @(negedge clk6x);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk6x);

        issue(0, 'hFF, 'h00, 1'b0, 0);       // single byte, ACK
        wait_idle();
        issue(1, 'hED, 'h07, 1'b1, 0);       // two bytes, ACK both
        wait_idle();
        issue(0, 'hF3, 'h20, 1'b1, 10);      // arg NACKed until retries run out
        wait_idle();
        issue(0, 'hF4, 'h00, 1'b0, 3);       // taken but never answered
        wait_idle();
        issue_both(0);
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 9) begin
                issue_both(-1);
            end else begin
                issue($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
                      1'($urandom), -1);
            end
            wait_idle();
        end

        // Reset while waiting on the command byte of a two-byte command.
        issue(1, 'hED, 'h02, 1'b1, 3);
        n = 0;
        while (cmd_tx_v_o && n < 20) begin
            @(negedge clk6x);
            n++;
        end
        repeat (3) @(negedge clk6x);
        chk("pre_reset_busy", sched_busy_o, 1);
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        exp_done.delete();
        exp_bytes.delete();
        plan.delete();
        last_grant = 1;
        repeat (3) @(negedge clk6x);
        reset = 1'b0;
        repeat (4) @(negedge clk6x);
        chk("post_reset_idle", sched_busy_o, 0);
        issue_both(-1);                      // fresh pointer: req0 takes the first tie
        wait_idle();
        repeat (5) @(negedge clk6x);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
